// File: rtl/bridge_dataslot_tracker.sv
// Tracks up to NUM_SLOTS bridge dataslots: base address, bytes written,
// announced size and load-complete flag per slot, observing the bus only.
// Ports:
//   clk, reset             bridge clock, synchronous active-high reset
//   dataslot_wr/addr       observed dataslot bus write strobe and byte address
//   req_valid/slot_id/size host_dataslot_request_write command
//   slot_base_address      captured base address per slot (32 bits each)
//   slot_base_found        base address captured, per slot
//   slot_size_zero         last request for the slot announced size 0
//   slot_loaded            byte count reached the announced size
//   slot_bytes             saturating bytes written since the slot was armed
//   active_valid/index     the slot currently ARMED or LOADING, if any
//   unknown_slot           one-cycle pulse on a request for an untracked ID
module bridge_dataslot_tracker #(
  parameter int                    NUM_SLOTS       = 4,
  parameter logic [16*NUM_SLOTS-1:0] SLOT_IDS      = {16'd3, 16'd2, 16'd1, 16'd0},
  parameter int                    BYTES_PER_WRITE = 4,
  localparam int                   IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dataslot_wr,
  input  logic [31:0]               dataslot_addr,
  input  logic                      req_valid,
  input  logic [15:0]               req_slot_id,
  input  logic [31:0]               req_expected_size,
  output logic [32*NUM_SLOTS-1:0]   slot_base_address,
  output logic [NUM_SLOTS-1:0]      slot_base_found,
  output logic [NUM_SLOTS-1:0]      slot_size_zero,
  output logic [NUM_SLOTS-1:0]      slot_loaded,
  output logic [32*NUM_SLOTS-1:0]   slot_bytes,
  output logic                      active_valid,
  output logic [IW-1:0]             active_index,
  output logic                      unknown_slot
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_LOADING,
    S_DONE
  } slot_state_t;

  slot_state_t          r_state [NUM_SLOTS];
  slot_state_t          w_state [NUM_SLOTS];
  logic [31:0]          r_base  [NUM_SLOTS];
  logic [31:0]          w_base  [NUM_SLOTS];
  logic [31:0]          r_bytes [NUM_SLOTS];
  logic [31:0]          w_bytes [NUM_SLOTS];
  logic [31:0]          r_size  [NUM_SLOTS];
  logic [31:0]          w_size  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_found, w_found;
  logic [NUM_SLOTS-1:0] r_zero,  w_zero;
  logic [NUM_SLOTS-1:0] r_loaded, w_loaded;
  logic                 r_act_valid, w_act_valid;
  logic [IW-1:0]        r_act_idx, w_act_idx;
  logic                 r_unknown, w_unknown;

  logic                 w_hit;
  logic [IW-1:0]        w_hit_idx;
  logic [32:0]          w_sum;
  logic [31:0]          w_bytes_inc;
  logic                 w_credit;

  // Scan from the top down so the lowest matching index wins on duplicates.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (SLOT_IDS[16*i +: 16] == req_slot_id) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_state[i] = r_state[i];
      w_base[i]  = r_base[i];
      w_bytes[i] = r_bytes[i];
      w_size[i]  = r_size[i];
    end
    w_found     = r_found;
    w_zero      = r_zero;
    w_loaded    = r_loaded;
    w_act_valid = r_act_valid;
    w_act_idx   = r_act_idx;
    w_unknown   = 1'b0;
    w_sum       = {1'b0, r_bytes[r_act_idx]} + 33'(BYTES_PER_WRITE);
    w_bytes_inc = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
    w_credit    = 1'b0;

    // Write phase: credited to the slot active before any same-cycle request.
    if (dataslot_wr && r_act_valid) begin
      unique case (1'b1)
        (r_state[r_act_idx] == S_LOADING): begin
          w_credit = 1'b1;
        end
        (r_state[r_act_idx] == S_ARMED): begin
          if (dataslot_addr[2:0] == 3'd0) begin
            w_credit            = 1'b1;
            w_base[r_act_idx]   = dataslot_addr;
            w_found[r_act_idx]  = 1'b1;
          end
        end
        default: ;
      endcase
      if (w_credit) begin
        w_bytes[r_act_idx] = w_bytes_inc;
        w_state[r_act_idx] = S_LOADING;
        if (w_bytes_inc >= r_size[r_act_idx]) begin
          w_loaded[r_act_idx] = 1'b1;
          w_state[r_act_idx]  = S_DONE;
          w_act_valid         = 1'b0;
        end
      end
    end

    // Request phase: overrides the write result for the re-requested slot.
    if (req_valid) begin
      if (w_hit) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (w_state[i] == S_ARMED || w_state[i] == S_LOADING) begin
            w_state[i]  = S_IDLE;
            w_loaded[i] = 1'b0;
          end
        end
        w_zero[w_hit_idx]  = (req_expected_size == 32'd0);
        w_found[w_hit_idx] = 1'b0;
        w_bytes[w_hit_idx] = 32'd0;
        w_size[w_hit_idx]  = req_expected_size;
        if (req_expected_size == 32'd0) begin
          w_state[w_hit_idx]  = S_DONE;
          w_loaded[w_hit_idx] = 1'b1;
          w_act_valid         = 1'b0;
        end else begin
          w_state[w_hit_idx]  = S_ARMED;
          w_loaded[w_hit_idx] = 1'b0;
          w_act_valid         = 1'b1;
          w_act_idx           = w_hit_idx;
        end
      end else begin
        w_unknown = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= S_IDLE;
        r_base[i]  <= '0;
        r_bytes[i] <= '0;
        r_size[i]  <= '0;
      end
      r_found     <= '0;
      r_zero      <= '1;
      r_loaded    <= '0;
      r_act_valid <= 1'b0;
      r_act_idx   <= '0;
      r_unknown   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= w_state[i];
        r_base[i]  <= w_base[i];
        r_bytes[i] <= w_bytes[i];
        r_size[i]  <= w_size[i];
      end
      r_found     <= w_found;
      r_zero      <= w_zero;
      r_loaded    <= w_loaded;
      r_act_valid <= w_act_valid;
      r_act_idx   <= w_act_idx;
      r_unknown   <= w_unknown;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
    assign slot_base_address[32*g +: 32] = r_base[g];
    assign slot_bytes[32*g +: 32]        = r_bytes[g];
  end

  assign slot_base_found = r_found;
  assign slot_size_zero  = r_zero;
  assign slot_loaded     = r_loaded;
  assign active_valid    = r_act_valid;
  assign active_index    = r_act_idx;
  assign unknown_slot    = r_unknown;

endmodule

// File: tb/tb_bridge_dataslot_tracker.sv
// Scoreboard bench for bridge_dataslot_tracker: stimulus queues expected
// register values per cycle, a negedge monitor pops and compares them.
module tb_bridge_dataslot_tracker;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          dataslot_wr;
  logic [31:0]   dataslot_addr;
  logic          req_valid;
  logic [15:0]   req_slot_id;
  logic [31:0]   req_expected_size;
  logic [32*N-1:0] slot_base_address;
  logic [N-1:0]  slot_base_found;
  logic [N-1:0]  slot_size_zero;
  logic [N-1:0]  slot_loaded;
  logic [32*N-1:0] slot_bytes;
  logic          active_valid;
  logic [1:0]    active_index;
  logic          unknown_slot;

  bridge_dataslot_tracker dut (
    .clk               (clk),
    .reset             (reset),
    .dataslot_wr       (dataslot_wr),
    .dataslot_addr     (dataslot_addr),
    .req_valid         (req_valid),
    .req_slot_id       (req_slot_id),
    .req_expected_size (req_expected_size),
    .slot_base_address (slot_base_address),
    .slot_base_found   (slot_base_found),
    .slot_size_zero    (slot_size_zero),
    .slot_loaded       (slot_loaded),
    .slot_bytes        (slot_bytes),
    .active_valid      (active_valid),
    .active_index      (active_index),
    .unknown_slot      (unknown_slot)
  );

  always #5 clk = ~clk;

  typedef enum int {
    K_BASE, K_FOUND, K_ZERO, K_LOADED, K_BYTES, K_AV, K_AI, K_UNK
  } kind_e;

  typedef struct {
    int          cyc;
    kind_e       kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] get(kind_e k, int i);
    case (k)
      K_BASE:   return slot_base_address[32*i +: 32];
      K_FOUND:  return {31'd0, slot_base_found[i]};
      K_ZERO:   return {28'd0, slot_size_zero};
      K_LOADED: return {31'd0, slot_loaded[i]};
      K_BYTES:  return slot_bytes[32*i +: 32];
      K_AV:     return {31'd0, active_valid};
      K_AI:     return {30'd0, active_index};
      default:  return {31'd0, unknown_slot};
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      chk_t c;
      logic [31:0] act;
      c   = q.pop_front();
      act = get(c.kind, c.idx);
      n_checks++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s[%0d] cyc %0d: actual %h required %h",
                 c.name, c.idx, cyc, act, c.exp);
      end
    end
  end

  task automatic e(kind_e k, int i, logic [31:0] v, string nm);
    chk_t c;
    c.cyc  = cyc + 1;
    c.kind = k;
    c.idx  = i;
    c.exp  = v;
    c.name = nm;
    q.push_back(c);
  endtask

  task automatic req(logic [15:0] id, logic [31:0] sz);
    req_valid         = 1'b1;
    req_slot_id       = id;
    req_expected_size = sz;
  endtask

  task automatic wr(logic [31:0] a);
    dataslot_wr   = 1'b1;
    dataslot_addr = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dataslot_wr       = 1'b0;
    dataslot_addr     = '0;
    req_valid         = 1'b0;
    req_slot_id       = '0;
    req_expected_size = '0;
  endtask

  initial begin
    reset             = 1'b1;
    dataslot_wr       = 1'b0;
    dataslot_addr     = '0;
    req_valid         = 1'b0;
    req_slot_id       = '0;
    req_expected_size = '0;
    tick();
    e(K_ZERO, 0, 32'hF, "rst_zero");
    e(K_AV, 0, 0, "rst_av");
    e(K_AI, 0, 0, "rst_ai");
    e(K_BYTES, 2, 0, "rst_bytes");
    e(K_BASE, 0, 0, "rst_base");
    e(K_UNK, 0, 0, "rst_unk");
    tick();
    reset = 1'b0;

    // slot 2, size 16, four aligned writes
    req(16'd2, 32'd16);
    e(K_AV, 0, 1, "t1_av");
    e(K_AI, 0, 2, "t1_ai");
    e(K_FOUND, 2, 0, "t1_found0");
    e(K_ZERO, 0, 32'hB, "t1_zero");
    tick();
    wr(32'h1000);
    e(K_BASE, 2, 32'h1000, "t1_base");
    e(K_FOUND, 2, 1, "t1_found");
    e(K_BYTES, 2, 4, "t1_b4");
    tick();
    wr(32'h1004);
    e(K_BYTES, 2, 8, "t1_b8");
    tick();
    wr(32'h1008);
    e(K_BYTES, 2, 12, "t1_b12");
    e(K_LOADED, 2, 0, "t1_ld0");
    tick();
    wr(32'h100C);
    e(K_BYTES, 2, 16, "t1_b16");
    e(K_LOADED, 2, 1, "t1_ld1");
    e(K_AV, 0, 0, "t1_av0");
    tick();

    // slot 1, size 0
    req(16'd1, 32'd0);
    e(K_ZERO, 0, 32'hB, "t2_zero");
    e(K_LOADED, 1, 1, "t2_ld");
    e(K_AV, 0, 0, "t2_av");
    tick();
    wr(32'h3000);
    e(K_BYTES, 1, 0, "t2_bytes");
    e(K_BASE, 1, 0, "t2_base");
    e(K_LOADED, 1, 1, "t2_ld_hold");
    e(K_BYTES, 2, 16, "t2_b2_hold");
    tick();

    // slot 0, size 64, unaligned first write ignored
    req(16'd0, 32'd64);
    e(K_AV, 0, 1, "t3_av");
    e(K_AI, 0, 0, "t3_ai");
    e(K_ZERO, 0, 32'hA, "t3_zero");
    tick();
    wr(32'h2004);
    e(K_FOUND, 0, 0, "t3_unal_found");
    e(K_BYTES, 0, 0, "t3_unal_bytes");
    tick();
    wr(32'h2008);
    e(K_BASE, 0, 32'h2008, "t3_base");
    e(K_BYTES, 0, 4, "t3_bytes");
    e(K_FOUND, 0, 1, "t3_found");
    tick();

    // slot 3 aborts slot 0, then request+write collide
    req(16'd3, 32'd32);
    e(K_AI, 0, 3, "t4_ai");
    e(K_BYTES, 0, 4, "t4_b0_hold");
    e(K_FOUND, 0, 1, "t4_f0_hold");
    e(K_ZERO, 0, 32'h2, "t4_zero");
    tick();
    wr(32'h4000);
    e(K_BYTES, 3, 4, "t4_b3_4");
    tick();
    wr(32'h4004);
    e(K_BYTES, 3, 8, "t4_b3_8");
    tick();
    wr(32'h4008);
    req(16'd0, 32'd8);
    e(K_BYTES, 3, 12, "t4_b3_12");
    e(K_LOADED, 3, 0, "t4_ld3");
    e(K_BYTES, 0, 0, "t4_b0_clr");
    e(K_FOUND, 0, 0, "t4_f0_clr");
    e(K_AI, 0, 0, "t4_ai0");
    e(K_AV, 0, 1, "t4_av");
    tick();
    wr(32'h5000);
    e(K_BASE, 0, 32'h5000, "t4_base0");
    e(K_BYTES, 0, 4, "t4_b0_4");
    e(K_BYTES, 3, 12, "t4_b3_idle");
    tick();

    // untracked ID
    req(16'h0099, 32'd40);
    e(K_UNK, 0, 1, "t5_unk1");
    e(K_AV, 0, 1, "t5_av");
    e(K_AI, 0, 0, "t5_ai");
    e(K_BYTES, 0, 4, "t5_b0");
    e(K_ZERO, 0, 32'h2, "t5_zero");
    tick();
    e(K_UNK, 0, 0, "t5_unk0");
    tick();

    // size 6 completes after two writes
    req(16'd1, 32'd6);
    e(K_AI, 0, 1, "t6_ai");
    e(K_ZERO, 0, 32'h0, "t6_zero");
    e(K_LOADED, 1, 0, "t6_ld0");
    tick();
    wr(32'h7000);
    e(K_BYTES, 1, 4, "t6_b4");
    e(K_LOADED, 1, 0, "t6_ld_mid");
    e(K_BYTES, 0, 4, "t6_b0_hold");
    tick();
    wr(32'h7004);
    e(K_BYTES, 1, 8, "t6_b8");
    e(K_LOADED, 1, 1, "t6_ld1");
    e(K_AV, 0, 0, "t6_av0");
    tick();

    // reset while slot 2 is loading
    req(16'd2, 32'd100);
    tick();
    wr(32'h6000);
    e(K_BYTES, 2, 4, "t7_b4");
    tick();
    reset = 1'b1;
    e(K_BYTES, 2, 0, "t7_bytes");
    e(K_BASE, 2, 0, "t7_base");
    e(K_FOUND, 2, 0, "t7_found");
    e(K_ZERO, 0, 32'hF, "t7_zero");
    e(K_LOADED, 1, 0, "t7_ld");
    e(K_AV, 0, 0, "t7_av");
    e(K_AI, 0, 0, "t7_ai");
    tick();
    reset = 1'b0;

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual %0d pending, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bridge_dataslot_tracker.md
Name: bridge_dataslot_tracker

Overview:
Multi-slot successor to the single-slot dataslot finder. It watches the bridge dataslot write bus and host_dataslot_request_write commands for up to NUM_SLOTS configured slot IDs. For each slot it tracks the announced size, the base address, the bytes written and a load-complete flag, so core logic can tell when each asset has landed. It sits beside the bridge, on the bridge clock, observing only and never driving the bus.

Parameters:
- NUM_SLOTS, 4, number of tracked slots (1..16).
- SLOT_IDS, {16'd3,16'd2,16'd1,16'd0}, packed NUM_SLOTS x 16-bit slot IDs; entry i is at bits [16*i+15:16*i]. On a duplicate ID, the lowest index wins.
- BYTES_PER_WRITE, 4, bytes credited per dataslot bus write.

Ports:
- clk  in  1  bridge clock.
- reset  in  1  synchronous, active-high reset.
- dataslot_wr  in  1  dataslot bus write strobe.
- dataslot_addr  in  32  dataslot bus byte address.
- req_valid  in  1  host_dataslot_request_write valid.
- req_slot_id  in  16  requested slot ID.
- req_expected_size  in  32  announced size in bytes.
- slot_base_address  out  32*NUM_SLOTS  captured base address per slot.
- slot_base_found  out  NUM_SLOTS  base address captured.
- slot_size_zero  out  NUM_SLOTS  last request announced size 0.
- slot_loaded  out  NUM_SLOTS  byte count reached the expected size.
- slot_bytes  out  32*NUM_SLOTS  bytes written since the slot was armed (saturating).
- active_valid  out  1  a slot is currently ARMED or LOADING.
- active_index  out  $clog2(NUM_SLOTS) (min 1)  index of the active slot.
- unknown_slot  out  1  one-cycle pulse when a request names an untracked ID.

Behaviour:
- Reset values:
  - base_address = 0, base_found = 0, slot_loaded = 0, slot_bytes = 0.
  - slot_size_zero = all 1s.
  - active_valid = 0, active_index = 0, unknown_slot = 0.
  - Every slot state = IDLE.
- Per-slot states: IDLE, ARMED, LOADING, DONE. At most one slot is in ARMED or LOADING at any time.
- Request with a matching ID (registered; outputs update the next cycle):
  - size_zero = (expected_size == 0); clear base_found, bytes and loaded; latch expected_size.
  - If size 0: state = DONE, loaded = 1, slot does not become active.
  - Otherwise: state = ARMED, active_index = i, active_valid = 1.
  - Any previously ARMED or LOADING slot (including the same slot) is aborted: state = IDLE, loaded = 0. Its base_found and bytes hold, except when it is the re-requested slot.
- Request with no matching ID: unknown_slot pulses for 1 cycle; all slot state is unchanged.
- ARMED:
  - Write with addr[2:0] == 0: capture base_address = addr, base_found = 1, bytes += BYTES_PER_WRITE, state = LOADING.
  - Unaligned write: ignored (not counted).
- LOADING: every write adds BYTES_PER_WRITE to bytes. The address is not checked.
- Completion: when the updated bytes >= expected size, the same edge sets loaded = 1, state = DONE and active_valid = 0.
  - Example: expected size 6 completes after 2 writes (bytes = 8).
- bytes saturates at 32'hFFFF_FFFF and never wraps.
- Writes while no slot is active are ignored.
- A write and a request in the same cycle: the write is credited to the slot that was active before the request. The request then applies as above; the re-requested slot's clear wins over the write.
- DONE persists until a new request names that slot.
- Reset mid-load returns everything to the reset values.
- No combinational path from inputs to outputs.

Test Plan:
- Request slot 2, size 16; writes at 0x1000, 0x1004, 0x1008, 0x100C. Required: base[2] = 0x1000, base_found[2] = 1 after the first write; slot_loaded[2] = 1 on the edge of the 4th write; slot_bytes[2] = 16; active_valid = 0.
- Request slot 1, size 0. Required: next cycle slot_size_zero[1] = 1, slot_loaded[1] = 1, active_valid = 0. Subsequent writes change nothing.
- Request slot 0, size 64; first write at 0x2004 then 0x2008. Required: the 0x2004 write is ignored; base[0] = 0x2008, slot_bytes[0] = 4.
- Request slot 3, size 32; 2 writes; then request slot 0, size 8 with a write in the same cycle. Required: slot 3 goes IDLE with bytes = 12, loaded = 0; slot 0 is ARMED with bytes = 0.
- Request ID 0x0099 (untracked). Required: unknown_slot high for exactly 1 cycle; all slot outputs unchanged.
- Assert reset while slot 2 is LOADING. Required: next cycle all outputs at reset values, slot_size_zero = all 1s.
